// File: rtl/dec_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// requester/index sizing.
package dec_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/dec_rr_arbiter_dec2to4.sv
// Combinational 2:4 one-hot decoder with enable; produces all-zero when disabled.
module dec2to4
  import dec_rr_arbiter_pkg::*;
(
  input  logic               en_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [NUM_REQ-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter over four requesters with a bounded hold time per tenure;
// the one-hot grant is the registered output of a shared 2:4 decoder.
module dec_rr_arbiter
  import dec_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] masked;
  logic               en_d;

  // Scan ptr, ptr+1, ... descending so the smallest offset is written last and wins.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] cand;
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = p + IDX_W'(i);
      if (r[cand]) pick = cand;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    masked  = req;
    masked[idx_q] = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          state_d = ST_GRANT;
          idx_d   = pick(req, ptr_q);
          ptr_d   = pick(req, ptr_q) + IDX_W'(1);
          cnt_d   = CNT_W'(1);
          en_d    = 1'b1;
        end
      end
      ST_GRANT: begin
        if (req[idx_q] && (cnt_q < CNT_W'(MAX_HOLD))) begin
          cnt_d = cnt_q + CNT_W'(1);
          en_d  = 1'b1;
        end else if (masked != '0) begin
          idx_d = pick(masked, ptr_q);
          ptr_d = pick(masked, ptr_q) + IDX_W'(1);
          cnt_d = CNT_W'(1);
          en_d  = 1'b1;
        end else if (req[idx_q]) begin
          // Expired with nobody else waiting: same holder starts a fresh tenure.
          cnt_d = CNT_W'(1);
          en_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dec2to4 u_dec (
    .en_i  (en_d),
    .idx_i (idx_d),
    .y_o   (gnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == ST_GRANT);

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed bench for dec_rr_arbiter; a MAX_HOLD=8 and a MAX_HOLD=1 instance share stimulus.
module tb_dec_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt, gnt1;
  logic [1:0] gntIdx, gntIdx1;
  logic       gntValid, gntValid1;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  dec_rr_arbiter #(.MAX_HOLD(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gntIdx),
    .gnt_valid (gntValid)
  );

  dec_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt1),
    .gnt_idx   (gntIdx1),
    .gnt_valid (gntValid1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive req, let one rising edge sample it, then settle before looking at outputs.
  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000);
    rst = 1'b0;
  endtask

  initial begin
    int h;
    int h1;

    // Reset held two cycles with all requests high.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b1111);
      checkOutput("rstGnt", 32'(gnt), 32'h0);
      checkOutput("rstValid", 32'(gntValid), 32'h0);
      checkOutput("rstIdx", 32'(gntIdx), 32'h0);
      checkOutput("rstGnt1", 32'(gnt1), 32'h0);
    end
    rst = 1'b0;

    // Single requester 2 for three cycles, then release.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100);
      checkOutput("singleGnt", 32'(gnt), 32'h4);
      checkOutput("singleIdx", 32'(gntIdx), 32'd2);
      checkOutput("singleValid", 32'(gntValid), 32'h1);
      checkOutput("singleGnt1", 32'(gnt1), 32'h4);
    end
    applyStimulus(4'b0000);
    checkOutput("releaseGnt", 32'(gnt), 32'h0);
    checkOutput("releaseValid", 32'(gntValid), 32'h0);
    checkOutput("releaseGnt1", 32'(gnt1), 32'h0);

    // All four requesting: tenures of 8 rotate 0,1,2,3,0,1; MAX_HOLD=1 rotates every cycle.
    doReset();
    for (int k = 1; k <= 42; k++) begin
      applyStimulus(4'b1111);
      h  = ((k - 1) / 8) % 4;
      h1 = (k - 1) % 4;
      checkOutput("rotGnt", 32'(gnt), 32'(1) << h);
      checkOutput("rotIdx", 32'(gntIdx), 32'(h));
      checkOutput("rotValid", 32'(gntValid), 32'h1);
      checkOutput("rotGnt1", 32'(gnt1), 32'(1) << h1);
    end

    // Holder 1 drops with req=1001 left; ptr=2 so requester 3 wins before 0.
    applyStimulus(4'b1001);
    checkOutput("handoffGnt", 32'(gnt), 32'h8);
    checkOutput("handoffIdx", 32'(gntIdx), 32'd3);
    checkOutput("handoffGnt1", 32'(gnt1), 32'h8);

    // Lone requester 1 across two expiries keeps the grant with no gap.
    doReset();
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(4'b0010);
      checkOutput("loneGnt", 32'(gnt), 32'h2);
      checkOutput("loneValid", 32'(gntValid), 32'h1);
    end

    // Reset mid-tenure drops the grant; afterwards requester 0 is first.
    doReset();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(4'b0100);
    end
    checkOutput("midGnt", 32'(gnt), 32'h4);
    rst = 1'b1;
    applyStimulus(4'b1111);
    checkOutput("midRstGnt", 32'(gnt), 32'h0);
    checkOutput("midRstValid", 32'(gntValid), 32'h0);
    checkOutput("midRstIdx", 32'(gntIdx), 32'h0);
    rst = 1'b0;
    applyStimulus(4'b1111);
    checkOutput("postRstGnt", 32'(gnt), 32'h1);
    checkOutput("postRstIdx", 32'(gntIdx), 32'h0);
    checkOutput("postRstGnt1", 32'(gnt1), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
